// File: rtl/turn_timer.sv
// Per-turn countdown timer: arms on a rising edge of start, counts down TURN_SECONDS whole
// seconds of CLK_HZ cycles, and pulses timeout once if the player has not moved in time.
module turn_timer #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned TURN_SECONDS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       move_done,
  output logic       running,
  output logic       timeout,
  output logic [6:0] secs_left,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  localparam int unsigned PreW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StExpired} state_e;

  state_e          state;
  logic [PreW-1:0] pre;
  logic            start_d;
  logic            start_rise;
  logic            tick;

  assign start_rise = start & ~start_d;
  assign tick       = (state == StRun) && (pre == PreW'(CLK_HZ - 1));
  assign running    = (state == StRun);

  always_comb begin
    tens = 4'(secs_left / 7'd10);
    ones = 4'(secs_left % 7'd10);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      pre       <= '0;
      secs_left <= '0;
      start_d   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      start_d <= start;
      timeout <= 1'b0;
      case (state)
        StIdle: begin
          if (start_rise) begin
            state     <= StRun;
            secs_left <= 7'(TURN_SECONDS);
            pre       <= '0;
          end
        end
        StRun: begin
          pre <= tick ? '0 : pre + PreW'(1);
          // Abort and move acceptance both outrank a tick on the same edge.
          if (!start || move_done) begin
            state     <= StIdle;
            secs_left <= '0;
          end else if (tick) begin
            if (secs_left == 7'd1) begin
              secs_left <= '0;
              state     <= StExpired;
              timeout   <= 1'b1;
            end else begin
              secs_left <= secs_left - 7'd1;
            end
          end
        end
        StExpired: begin
          // Holding start high must not re-arm; wait for it to drop first.
          secs_left <= '0;
          if (!start) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_timer.sv
// Bench for turn_timer: two instances (4 Hz/3 s and 2 Hz/15 s) checked every cycle against a
// time-stamp model of the countdown, plus directed literal expectations.
module tb_turn_timer;

  localparam int HZ [2] = '{4, 2};
  localparam int TS [2] = '{3, 15};

  logic       clk;
  logic       rst;
  logic [1:0] st;
  logic [1:0] md;
  logic [1:0] run;
  logic [1:0] to;
  logic [6:0] secs [2];
  logic [3:0] tn [2];
  logic [3:0] on [2];

  int n_checks;
  int n_pass;
  int cyc;

  // Model: a turn is described by when it was armed; everything else follows from elapsed time.
  bit m_counting [2];
  bit m_expired  [2];
  bit m_prev     [2];
  bit m_to       [2];
  int m_arm      [2];

  turn_timer #(.CLK_HZ(4), .TURN_SECONDS(3)) dut_a (
    .clk(clk), .rst(rst), .start(st[0]), .move_done(md[0]), .running(run[0]),
    .timeout(to[0]), .secs_left(secs[0]), .tens(tn[0]), .ones(on[0])
  );

  turn_timer #(.CLK_HZ(2), .TURN_SECONDS(15)) dut_b (
    .clk(clk), .rst(rst), .start(st[1]), .move_done(md[1]), .running(run[1]),
    .timeout(to[1]), .secs_left(secs[1]), .tens(tn[1]), .ones(on[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
  endtask

  function automatic int exp_secs(input int i);
    if (!m_counting[i]) return 0;
    return TS[i] - (cyc - m_arm[i]) / HZ[i];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_counting[i] = 1'b0;
        m_expired[i]  = 1'b0;
        m_prev[i]     = 1'b0;
        m_to[i]       = 1'b0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        m_to[i] = 1'b0;
        if (m_counting[i]) begin
          if (!st[i] || md[i]) m_counting[i] = 1'b0;
          else if (cyc - m_arm[i] == TS[i] * HZ[i]) begin
            m_counting[i] = 1'b0;
            m_expired[i]  = 1'b1;
            m_to[i]       = 1'b1;
          end
        end else if (m_expired[i]) begin
          if (!st[i]) m_expired[i] = 1'b0;
        end else if (st[i] && !m_prev[i]) begin
          m_counting[i] = 1'b1;
          m_arm[i]      = cyc;
        end
        m_prev[i] = st[i];
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("running", int'(run[i]), int'(m_counting[i]));
      chk("timeout", int'(to[i]), int'(m_to[i]));
      chk("secs_left", int'(secs[i]), exp_secs(i));
      chk("tens", int'(tn[i]), exp_secs(i) / 10);
      chk("ones", int'(on[i]), exp_secs(i) % 10);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    for (int i = 0; i < 2; i++) begin
      m_counting[i] = 1'b0;
      m_expired[i]  = 1'b0;
      m_prev[i]     = 1'b0;
      m_to[i]       = 1'b0;
      m_arm[i]      = 0;
    end
    rst = 1'b0;
    st  = '0;
    md  = '0;
    step(3);
    chk("reset_secs", int'(secs[0]), 0);
    rst = 1'b1;
    step(2);

    // Full countdown to expiry.
    st[0] = 1'b1;
    step(1);
    chk("arm_secs", int'(secs[0]), 3);
    chk("arm_running", int'(run[0]), 1);
    step(4);
    chk("tick1_secs", int'(secs[0]), 2);
    step(4);
    chk("tick2_secs", int'(secs[0]), 1);
    step(4);
    chk("expire_timeout", int'(to[0]), 1);
    chk("expire_running", int'(run[0]), 0);
    chk("expire_secs", int'(secs[0]), 0);
    step(1);
    chk("timeout_cleared", int'(to[0]), 0);

    // Held start must not re-arm; a low-then-high cycle does.
    step(20);
    chk("held_no_rearm", int'(run[0]), 0);
    st[0] = 1'b0;
    step(1);
    st[0] = 1'b1;
    step(1);
    chk("rearm_secs", int'(secs[0]), 3);

    // move_done mid-count at E0+6.
    step(5);
    md[0] = 1'b1;
    step(1);
    md[0] = 1'b0;
    chk("move_running", int'(run[0]), 0);
    chk("move_secs", int'(secs[0]), 0);
    step(12);

    // move_done coincident with the expiring edge.
    st[0] = 1'b0;
    step(1);
    st[0] = 1'b1;
    step(12);
    md[0] = 1'b1;
    step(1);
    md[0] = 1'b0;
    chk("coincident_timeout", int'(to[0]), 0);
    chk("coincident_running", int'(run[0]), 0);
    step(3);

    // Start fall aborts.
    st[0] = 1'b0;
    step(1);
    st[0] = 1'b1;
    step(3);
    st[0] = 1'b0;
    step(1);
    chk("abort_running", int'(run[0]), 0);
    step(2);

    // Asynchronous reset mid-count, then a normal re-arm.
    st[0] = 1'b1;
    step(6);
    chk("pre_reset_secs", int'(secs[0]), 2);
    #2 rst = 1'b0;
    #1;
    chk("async_running", int'(run[0]), 0);
    chk("async_secs", int'(secs[0]), 0);
    chk("async_ones", int'(on[0]), 0);
    st[0] = 1'b0;
    step(2);
    rst = 1'b1;
    step(2);
    chk("post_reset_idle", int'(run[0]), 0);
    st[0] = 1'b1;
    step(1);
    chk("post_reset_arm", int'(secs[0]), 3);
    st[0] = 1'b0;
    step(2);

    // Two-digit BCD on the 15 s instance.
    st[1] = 1'b1;
    step(1);
    chk("bcd15_tens", int'(tn[1]), 1);
    chk("bcd15_ones", int'(on[1]), 5);
    step(2);
    chk("bcd14_tens", int'(tn[1]), 1);
    chk("bcd14_ones", int'(on[1]), 4);
    step(10);
    chk("bcd9_tens", int'(tn[1]), 0);
    chk("bcd9_ones", int'(on[1]), 9);
    step(18);
    chk("b_expire_timeout", int'(to[1]), 1);
    step(3);
    st[1] = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
